// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and digit-code helper
// for the multiplexed seven-segment display scanner.
package disp_pkg;

    localparam int NDIG = 6;
    localparam logic [3:0] BLANK_CODE = 4'b0000;
    localparam logic [5:0] DIG_OFF = 6'b111111;

    // Decoder expects the inverted BCD code; non-decimal nibbles blank.
    function automatic logic [3:0] bcd_code(
        input logic [3:0] n
    );
        if (n > 4'd9) begin
            return BLANK_CODE;
        end
        return ~n;
    endfunction

endpackage

// File: rtl/disp_scan.sv
// disp_scan: six-digit multiplexed display scanner with
// frame-aligned value update and leading-zero blanking.
module disp_scan
    import disp_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  bcd_n,
    output logic [5:0]  dig,
    output logic        pending,
    output logic        frame
);

    localparam int PW = (TICKS_PER_DIGIT > 2) ?
        $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [PW-1:0] PMAX =
        PW'(TICKS_PER_DIGIT - 1);
    localparam logic [2:0] IDX_LAST = 3'(NDIG - 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [23:0]   disp_reg;
    logic [23:0]   pend_reg;
    logic          tick;
    logic          boundary;

    logic [3:0]    nib [NDIG];
    logic [NDIG-1:0] zero_up;
    logic [3:0]    cur_nib;
    logic          cur_zero;
    logic [3:0]    cur_code;

    assign tick = (presc == PMAX);
    assign boundary = tick && (idx == IDX_LAST);

    // zero_up[i]: digits i..5 are all zero
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            nib[i] = disp_reg[4*i +: 4];
        end
        zero_up[NDIG-1] = (nib[NDIG-1] == 4'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            zero_up[i] = zero_up[i+1] && (nib[i] == 4'd0);
        end
    end

    always_comb begin
        cur_nib  = nib[0];
        cur_zero = 1'b0;
        case (idx)
            3'd1: begin
                cur_nib  = nib[1];
                cur_zero = zero_up[1];
            end
            3'd2: begin
                cur_nib  = nib[2];
                cur_zero = zero_up[2];
            end
            3'd3: begin
                cur_nib  = nib[3];
                cur_zero = zero_up[3];
            end
            3'd4: begin
                cur_nib  = nib[4];
                cur_zero = zero_up[4];
            end
            3'd5: begin
                cur_nib  = nib[5];
                cur_zero = zero_up[5];
            end
            default: begin
                cur_nib  = nib[0];
                cur_zero = 1'b0;
            end
        endcase
        cur_code = (blank_lz && cur_zero) ?
            BLANK_CODE : bcd_code(cur_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // A load on the boundary bypasses the pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_reg <= '0;
            pend_reg <= '0;
            pending  <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp_reg <= value;
            end else if (pending) begin
                disp_reg <= pend_reg;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_reg <= value;
            pending  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig   <= DIG_OFF;
            bcd_n <= BLANK_CODE;
            frame <= 1'b0;
        end else begin
            dig   <= DIG_OFF & ~(6'b1 << idx);
            bcd_n <= cur_code;
            frame <= boundary;
        end
    end

endmodule
